// File: rtl/full_adder_pkg.sv
// Purpose: shared constants and the result record for the registered ripple adder.
// Latency: not applicable (types and constants only).
// Backpressure: not applicable.
package full_adder_pkg;

    // Default operand width and the widest operand the adder is meant to support
    localparam int DEFAULT_WIDTH = 1;
    localparam int MAX_WIDTH     = 64;

    // Adder result record sized for the widest operand; narrower users zero-extend sum
    typedef struct packed {
        logic                 cout;
        logic                 overflow;
        logic [MAX_WIDTH-1:0] sum;
    } fa_result_t;

    // Signed overflow from the carries into and out of the MSB
    function automatic logic signed_ovf(input logic carry_into_msb, input logic carry_out_msb);
        return carry_into_msb ^ carry_out_msb;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Purpose: one-bit combinational full adder cell, a link of the ripple chain.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic prop;

    // Propagate term shared by the sum and the carry equations
    assign prop = a ^ b;
    assign sum  = prop ^ cin;
    assign cout = (a & b) | (cin & prop);

endmodule

// File: rtl/full_adder.sv
// Purpose: WIDTH-bit ripple-carry adder with registered sum, carry-out and signed overflow.
// Latency: 1 cycle from an in_valid input to sum/cout/overflow/out_valid.
// Backpressure: none; accepts one input every cycle, outputs hold while in_valid is low.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             out_valid
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;
    logic             ovf_comb;

    logic [WIDTH-1:0] sum_d,       sum_q;
    logic             cout_d,      cout_q;
    logic             overflow_d,  overflow_q;
    logic             out_valid_d, out_valid_q;

    assign carry[0] = cin;

    // Purely combinational ripple chain, one cell per operand bit
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum_comb[i]),
            .cout (carry[i+1])
        );
    end

    // For WIDTH=1 the carry into the MSB is cin itself
    assign ovf_comb = signed_ovf(carry[WIDTH-1], carry[WIDTH]);

    // Next-state: load a fresh result on in_valid, otherwise hold (keeps X inputs out of the outputs)
    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            sum_d       = sum_comb;
            cout_d      = carry[WIDTH];
            overflow_d  = ovf_comb;
            out_valid_d = 1'b1;
        end
    end

    // Output stage registers; synchronous reset wins over a simultaneous valid input
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Purpose: directed self-checking bench for full_adder at WIDTH=1 and WIDTH=8.
// Latency: expects results exactly one clk after each accepted input.
// Backpressure: none exercised; inputs are driven every cycle.
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       a1, b1, cin1, in_valid1;
    logic       sum1, cout1, overflow1, out_valid1;

    logic [7:0] a8, b8, sum8;
    logic       cin8, in_valid8;
    logic       cout8, overflow8, out_valid8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .in_valid  (in_valid1),
        .sum       (sum1),
        .cout      (cout1),
        .overflow  (overflow1),
        .out_valid (out_valid1)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .in_valid  (in_valid8),
        .sum       (sum8),
        .cout      (cout8),
        .overflow  (overflow8),
        .out_valid (out_valid8)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] s, input logic c, input logic o, input logic v);
        check_eq({tag, ".sum8"},  64'(sum8),       64'(s));
        check_eq({tag, ".cout8"}, 64'(cout8),      64'(c));
        check_eq({tag, ".ovf8"},  64'(overflow8),  64'(o));
        check_eq({tag, ".vld8"},  64'(out_valid8), 64'(v));
    endtask

    task automatic check1(input string tag, input logic s, input logic c, input logic o, input logic v);
        check_eq({tag, ".sum1"},  64'(sum1),       64'(s));
        check_eq({tag, ".cout1"}, 64'(cout1),      64'(c));
        check_eq({tag, ".ovf1"},  64'(overflow1),  64'(o));
        check_eq({tag, ".vld1"},  64'(out_valid1), 64'(v));
    endtask

    initial begin
        logic [1:0] s1;
        logic       ea, eb, ec;
        logic [7:0] hold_s;
        logic       hold_c, hold_o;
        logic [2:0] vec;

        // Reset held together with valid inputs: everything must stay zero
        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; in_valid1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; in_valid8 = 1'b1;
        step();
        check1("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check8("rst", 8'h00, 1'b0, 1'b0, 1'b0);

        // Release reset: 3 + 4 + 0 shows up exactly one cycle later, then valid drops
        rst_n = 1'b1;
        in_valid1 = 1'b0;
        a8 = 8'd3; b8 = 8'd4; cin8 = 1'b0; in_valid8 = 1'b1;
        step();
        check8("post_rst", 8'd7, 1'b0, 1'b0, 1'b1);
        in_valid8 = 1'b0;
        step();
        check8("post_rst_hold", 8'd7, 1'b0, 1'b0, 1'b0);

        // WIDTH=1 directed: 0+0+1, 1+0+1, 1+1+0
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b1; in_valid1 = 1'b1;
        step();
        check1("w1_001", 1'b1, 1'b0, 1'b1, 1'b1);
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1;
        step();
        check1("w1_101", 1'b0, 1'b1, 1'b0, 1'b1);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
        step();
        check1("w1_110", 1'b0, 1'b1, 1'b1, 1'b1);
        in_valid1 = 1'b0;

        // WIDTH=8 directed: signed overflow at 0x7F+1, all-ones wrap
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; in_valid8 = 1'b1;
        step();
        check8("w8_7f_01", 8'h80, 1'b0, 1'b1, 1'b1);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        step();
        check8("w8_ff_ff_1", 8'hFF, 1'b1, 1'b0, 1'b1);

        // Idle with random (and X) operands: registered results hold, out_valid low
        hold_s = 8'hFF; hold_c = 1'b1; hold_o = 1'b0;
        in_valid8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            a1 = 1'bx; b1 = 1'bx; cin1 = 1'bx;
            step();
            check8($sformatf("idle%0d", i), hold_s, hold_c, hold_o, 1'b0);
            check1($sformatf("idle%0d", i), 1'b0, 1'b1, 1'b1, 1'b0);
        end

        // Exhaustive WIDTH=1 sweep, back-to-back with in_valid held high
        in_valid1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vec = 3'(i);
            ea = vec[2]; eb = vec[1]; ec = vec[0];
            a1 = ea; b1 = eb; cin1 = ec;
            s1 = {1'b0, ea} + {1'b0, eb} + {1'b0, ec};
            step();
            check1($sformatf("sweep%0d", i), s1[0], s1[1], ec ^ s1[1], 1'b1);
        end
        in_valid1 = 1'b0;
        step();
        check_eq("sweep_end.vld1", 64'(out_valid1), 64'd0);

        // Mid-stream reset drops the in-flight input; first valid afterwards appears one cycle later
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; in_valid8 = 1'b1;
        rst_n = 1'b0;
        step();
        check8("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        in_valid8 = 1'b0;
        step();
        check8("mid_rst_idle", 8'h00, 1'b0, 1'b0, 1'b0);
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1; in_valid8 = 1'b1;
        step();
        check8("mid_rst_first", 8'h01, 1'b1, 1'b1, 1'b1);
        in_valid8 = 1'b0;
        step();
        check8("mid_rst_after", 8'h01, 1'b1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
